// File: rtl/wilson_integrator.sv
// Sequential wrapper around the Wilson-neuron Euler-step datapath: state hold, run control,
// decimated sample stream and spike counting. Optional overflow guard: WILSON_OVF_GUARD_EN.
module wilson_integrator #(
  parameter int unsigned STEPS_W  = 16,
  parameter int unsigned DECIM    = 16,
  parameter logic [31:0] V_INIT   = 32'h8000B333,
  parameter logic [31:0] R_INIT   = 32'h00001687,
  parameter logic [31:0] SPIKE_TH = 32'h00000000
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [STEPS_W-1:0] num_steps,
  input  logic               abort,
  output logic [31:0]        v_state,
  output logic [31:0]        r_state,
  input  logic [31:0]        v_next,
  input  logic [31:0]        r_next,
  output logic               sample_valid,
  input  logic               sample_ready,
  output logic [31:0]        sample_v,
  output logic [31:0]        sample_r,
  output logic               spike,
  output logic [15:0]        spike_count,
  output logic               busy,
`ifdef WILSON_OVF_GUARD_EN
  output logic               ovf,
`endif
  output logic               done
);

  localparam int unsigned DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [30:0] OVF_LIM = 31'h00640000;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [STEPS_W-1:0] ns_q, ns_d, step_q, step_d;
  logic [DEC_W-1:0]   dec_q, dec_d;
  logic [31:0]        v_q, v_d, r_q, r_d, sv_v_q, sv_v_d, sv_r_q, sv_r_d;
  logic               sv_q, sv_d, spike_q, spike_d, busy_q, busy_d, done_q, done_d;
  logic [15:0]        spk_cnt_q, spk_cnt_d;
  logic               dec_wrap_c, stall_c, ovf_hit_c;

  // Sign-magnitude less-than; -0 and +0 compare equal.
  function automatic logic sm_lt(input logic [31:0] a, input logic [31:0] b);
    logic a_neg, b_neg;
    a_neg = a[31] & (|a[30:0]);
    b_neg = b[31] & (|b[30:0]);
    if (a_neg != b_neg) return a_neg;
    if (a_neg)          return a[30:0] > b[30:0];
    return a[30:0] < b[30:0];
  endfunction

  assign dec_wrap_c = (dec_q == DEC_W'(DECIM - 1));
  // Only a step that would overwrite an unaccepted sample is held back.
  assign stall_c    = sv_q & ~sample_ready & dec_wrap_c;

`ifdef WILSON_OVF_GUARD_EN
  assign ovf_hit_c = (v_next[30:0] >= OVF_LIM);
`else
  assign ovf_hit_c = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      ns_q      <= '0;
      step_q    <= '0;
      dec_q     <= '0;
      v_q       <= V_INIT;
      r_q       <= R_INIT;
      sv_q      <= 1'b0;
      sv_v_q    <= '0;
      sv_r_q    <= '0;
      spike_q   <= 1'b0;
      spk_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ns_q      <= ns_d;
      step_q    <= step_d;
      dec_q     <= dec_d;
      v_q       <= v_d;
      r_q       <= r_d;
      sv_q      <= sv_d;
      sv_v_q    <= sv_v_d;
      sv_r_q    <= sv_r_d;
      spike_q   <= spike_d;
      spk_cnt_q <= spk_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ns_d      = ns_q;
    step_d    = step_q;
    dec_d     = dec_q;
    v_d       = v_q;
    r_d       = r_q;
    sv_d      = sv_q;
    sv_v_d    = sv_v_q;
    sv_r_d    = sv_r_q;
    spike_d   = 1'b0;
    spk_cnt_d = spk_cnt_q;

    if (sv_q && sample_ready) sv_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          ns_d      = num_steps;
          v_d       = V_INIT;
          r_d       = R_INIT;
          step_d    = '0;
          dec_d     = '0;
          spk_cnt_d = '0;
          state_d   = (num_steps == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (abort || ovf_hit_c) begin
          state_d = S_DRAIN;
        end else if (!stall_c) begin
          v_d    = v_next;
          r_d    = r_next;
          step_d = step_q + STEPS_W'(1);
          if (dec_wrap_c) begin
            dec_d  = '0;
            sv_d   = 1'b1;
            sv_v_d = v_next;
            sv_r_d = r_next;
          end else begin
            dec_d = dec_q + DEC_W'(1);
          end
          if (sm_lt(v_q, SPIKE_TH) && !sm_lt(v_next, SPIKE_TH)) begin
            spike_d = 1'b1;
            if (spk_cnt_q != 16'hFFFF) spk_cnt_d = spk_cnt_q + 16'd1;
          end
          if (step_q == ns_q - STEPS_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          sv_d    = 1'b0;
          state_d = S_DONE;
        end else if (!sv_q || sample_ready) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

`ifdef WILSON_OVF_GUARD_EN
  logic ovf_q, ovf_d;

  // Sticky overflow flag, cleared only by an accepted start.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == S_IDLE && start)                     ovf_d = 1'b0;
    else if (state_q == S_RUN && !abort && ovf_hit_c)   ovf_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ovf_q <= 1'b0;
    else          ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

  assign v_state      = v_q;
  assign r_state      = r_q;
  assign sample_valid = sv_q;
  assign sample_v     = sv_v_q;
  assign sample_r     = sv_r_q;
  assign spike        = spike_q;
  assign spike_count  = spk_cnt_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_wilson_integrator.sv
// Scoreboard bench for wilson_integrator with a behavioural step datapath in loopback.
module tb_wilson_integrator;

  localparam int unsigned DECIM  = 4;
  localparam logic [31:0] V_INIT = 32'h8000B333;
  localparam logic [31:0] R_INIT = 32'h00001687;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_steps = '0;
  logic        abort = 1'b0;
  logic [31:0] v_state, r_state, v_next, r_next, sample_v, sample_r;
  logic        sample_valid, spike, busy, done;
  logic        sample_ready = 1'b1;
  logic [15:0] spike_count;
`ifdef WILSON_OVF_GUARD_EN
  logic        ovf;
`endif

  typedef struct packed { logic [31:0] v; logic [31:0] r; } smp_t;
  smp_t exp_q[$];
  smp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   mode  = 0;
  logic [31:0] mask;

  wilson_integrator #(.STEPS_W(16), .DECIM(DECIM)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .num_steps(num_steps), .abort(abort),
    .v_state(v_state), .r_state(r_state), .v_next(v_next), .r_next(r_next),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample_v(sample_v), .sample_r(sample_r), .spike(spike), .spike_count(spike_count),
    .busy(busy),
`ifdef WILSON_OVF_GUARD_EN
    .ovf(ovf),
`endif
    .done(done)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] sm_add1(input logic [31:0] v);
    if (!v[31] || v[30:0] == 31'd0) return {1'b0, v[30:0] + 31'h10000};
    if (v[30:0] > 31'h10000)        return {1'b1, v[30:0] - 31'h10000};
    return {1'b0, 31'h10000 - v[30:0]};
  endfunction

  function automatic logic [31:0] spike_map(input logic [31:0] v);
    case (v)
      32'h8000B333: return 32'h80010000;
      32'h80010000: return 32'h80000000;
      32'h80000000: return 32'h00008000;
      32'h00008000: return 32'h80008000;
      32'h80008000: return 32'h00008000;
      default:      return sm_add1(v);
    endcase
  endfunction

  // Loopback datapath: mode 0 adds 1.0, mode 1 walks the spike table, mode 2 overflows after step 1.
  always_comb begin
    r_next = r_state + 32'd1;
    case (mode)
      1:       v_next = spike_map(v_state);
      2:       v_next = (v_state == 32'h00004CCD) ? 32'h00640000 : sm_add1(v_state);
      default: v_next = sm_add1(v_state);
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n && sample_valid && sample_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_sample: got v=%h r=%h expected none", sample_v, sample_r);
      end else begin
        mon_e = exp_q.pop_front();
        check("sample_v", sample_v, mon_e.v);
        check("sample_r", sample_r, mon_e.r);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic [15:0] ns);
    tick();
    start = 1'b1;
    num_steps = ns;
    tick();
    start = 1'b0;
  endtask

  // Cycle 0 is just after the accepting edge; inj_kind 1 = stray start, 2 = abort.
  task automatic run_wait(input int inj_cyc, input int inj_kind, input int exp_done,
                          input string name, output logic [31:0] smask);
    int  n;
    bit  seen;
    smask = '0;
    seen  = 1'b0;
    for (n = 0; n < 40; n++) begin
      if (spike && n < 32) smask[n] = 1'b1;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (n == inj_cyc) begin
        if (inj_kind == 1) begin start = 1'b1; num_steps = 16'd3; end
        else               abort = 1'b1;
      end
      tick();
      start = 1'b0;
      abort = 1'b0;
    end
    n_cmp++;
    if (!seen || n != exp_done) begin
      n_bad++;
      $display("FAIL %s_done_cycle: got %0d (seen=%0d) expected %0d", name, n, seen, exp_done);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    check("rst_v_state", v_state, V_INIT);
    check("rst_r_state", r_state, R_INIT);
    check("rst_outputs", {31'd0, sample_valid | spike | busy | done}, 32'd0);
    check("rst_spike_count", {16'd0, spike_count}, 32'd0);
    reset_n = 1'b1;

    // Plain run, 8 steps, two samples.
    exp_q.push_back('{32'h00034CCD, R_INIT + 32'd4});
    exp_q.push_back('{32'h00074CCD, R_INIT + 32'd8});
    do_start(16'd8);
    check("run_busy", {31'd0, busy}, 32'd1);
    run_wait(-1, 0, 9, "run", mask);
    check("run_spike_mask", mask, 32'h2);
    check("run_v_final", v_state, 32'h00074CCD);
    check("run_spike_count", {16'd0, spike_count}, 32'd1);

    // Backpressure: steps 5..7 proceed, step 8 holds until the first sample is taken.
    sample_ready = 1'b0;
    exp_q.push_back('{32'h00034CCD, R_INIT + 32'd4});
    exp_q.push_back('{32'h00074CCD, R_INIT + 32'd8});
    do_start(16'd8);
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c >= 4) check("bp_hold_v", sample_v, 32'h00034CCD);
    end
    check("bp_valid", {31'd0, sample_valid}, 32'd1);
    check("bp_v_frozen", v_state, 32'h00064CCD);
    sample_ready = 1'b1;
    run_wait(-1, 0, 2, "bp", mask);

    // Spike sequence -1.0, -0.0, +0.5, -0.5, +0.5.
    mode = 1;
    exp_q.push_back('{32'h80008000, R_INIT + 32'd4});
    do_start(16'd5);
    run_wait(-1, 0, 6, "spk", mask);
    check("spk_mask", mask, 32'h24);
    check("spk_count", {16'd0, spike_count}, 32'd2);
    mode = 0;

    // Zero-step run.
    do_start(16'd0);
    check("zero_valid", {31'd0, sample_valid}, 32'd0);
    run_wait(-1, 0, 0, "zero", mask);
    check("zero_busy", {31'd0, busy}, 32'd0);

    // Stray start in RUN is ignored.
    exp_q.push_back('{32'h00034CCD, R_INIT + 32'd4});
    exp_q.push_back('{32'h00074CCD, R_INIT + 32'd8});
    do_start(16'd8);
    run_wait(2, 1, 9, "ign", mask);
    check("ign_v_final", v_state, 32'h00074CCD);

    // Abort after step 3.
    do_start(16'd8);
    run_wait(3, 2, 5, "abort", mask);
    check("abort_v", v_state, 32'h00024CCD);
    check("abort_r", r_state, R_INIT + 32'd3);

    // Asynchronous reset mid-run with a pending sample.
    sample_ready = 1'b0;
    do_start(16'd8);
    repeat (5) tick();
    check("pre_rst_valid", {31'd0, sample_valid}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("arst_v_state", v_state, V_INIT);
    check("arst_r_state", r_state, R_INIT);
    check("arst_valid_busy", {30'd0, sample_valid, busy}, 32'd0);
    check("arst_sample_v", sample_v, 32'd0);
    check("arst_spike_count", {16'd0, spike_count}, 32'd0);
    tick();
    reset_n = 1'b1;
    sample_ready = 1'b1;

`ifdef WILSON_OVF_GUARD_EN
    mode = 2;
    do_start(16'd8);
    run_wait(-1, 0, 3, "ovf", mask);
    check("ovf_v_hold", v_state, 32'h00004CCD);
    check("ovf_flag", {31'd0, ovf}, 32'd1);
    repeat (3) tick();
    check("ovf_sticky", {31'd0, ovf}, 32'd1);
    mode = 0;
    do_start(16'd0);
    check("ovf_cleared", {31'd0, ovf}, 32'd0);
`endif

    repeat (3) tick();
    check("scoreboard_left", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
